// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_stage                                                           |
// | RV32 memory-access stage: load/store request/grant/response sequencing,    |
// | store lane steering, load alignment/extension and pipeline stall control.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] pc_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(RSP_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_mem_data;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_mem_op;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_fault;
  logic        w_expired;
  logic        w_timeout;
  logic [15:0] w_lane;
  logic [31:0] w_load_data;

  assign w_mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_illegal = (ex_funct3[1:0] == 2'b11) | (ex_funct3[2:1] == 2'b11);
  assign w_fault   = w_illegal | w_misaligned;
  assign w_expired = (r_cnt >= c_TIMEOUT_LAST);

  always_comb begin
    w_misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   w_misaligned = ex_alu_result[0];
      2'b10:   w_misaligned = |ex_alu_result[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A load granted on the final budgeted cycle has no time left for its
  // response, so expiry outranks a load grant but never a store grant.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_stall = w_mem_op;
        if (w_mem_op) begin
          w_next = w_fault ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_gnt && ex_mem_write) begin
          w_next = S_DONE;
        end else if (w_expired) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end else if (dmem_gnt) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          w_next = S_DONE;
        end else if (w_expired) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (!rst_n) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 8'd0;
      r_mem_data <= 32'd0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_cnt      <= 8'd0;
            r_mem_data <= 32'd0;
            r_misalign <= w_fault;
            r_bus_err  <= 1'b0;
          end
        end
        S_ADDR: begin
          r_cnt     <= r_cnt + 8'd1;
          r_bus_err <= w_timeout;
        end
        S_DATA: begin
          r_cnt     <= r_cnt + 8'd1;
          r_bus_err <= w_timeout;
          if (dmem_rvalid) begin
            r_mem_data <= w_load_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_lane      = 16'(dmem_rdata >> {ex_alu_result[1:0], 3'b000});
    w_load_data = dmem_rdata;
    case (ex_funct3[1:0])
      2'b00:   w_load_data = ex_funct3[2] ? {24'd0, w_lane[7:0]}
                                          : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_data = ex_funct3[2] ? {16'd0, w_lane[15:0]}
                                          : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_wdata = ex_store_data;
    dmem_be    = 4'b1111;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          dmem_wdata = {4{ex_store_data[7:0]}};
          dmem_be    = 4'b0001 << ex_alu_result[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{ex_store_data[15:0]}};
          dmem_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = ex_store_data;
          dmem_be    = 4'b1111;
        end
      endcase
    end
  end

  assign dmem_addr    = {ex_alu_result[31:2], 2'b00};
  assign dmem_we      = ex_mem_write;
  assign pc_o         = ex_pc;
  assign alu_result_o = ex_alu_result;
  assign rd_addr_o    = ex_rd_addr;
  assign wb_sel_o     = ex_wb_sel;
  assign mem_data_o   = r_mem_data;
  assign misalign_o   = r_misalign & (r_state == S_DONE);
  assign bus_err_o    = r_bus_err & (r_state == S_DONE);
  assign reg_write_o  = ex_valid & ex_reg_write &
                        ~((r_state == S_DONE) & (r_misalign | r_bus_err));

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_stage                                                        |
// | Scoreboard bench with a randomized memory responder for mem_access_stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_pc, ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd_addr;
  logic [1:0]  ex_wb_sel;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, reg_write_o, misalign_o, bus_err_o;
  logic [31:0] pc_o, alu_result_o, mem_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  wb_sel_o;

  always #5 clk = ~clk;

  mem_access_stage #(.RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .pc_o(pc_o), .alu_result_o(alu_result_o), .mem_data_o(mem_data_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    int          stall;
    int          req_cycles;
    logic [31:0] addr, wdata, mem_data, pc, alu;
    logic [3:0]  be;
    logic        we, reg_write, misalign, bus_err;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_mem_data = 32'd0;
  int          cur_g = 0;
  int          cur_r = 0;
  logic [31:0] cur_rdata = 32'd0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b1;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: grants after cur_g waiting cycles, answers loads cur_r cycles later
  initial begin
    int acnt, rcnt;
    bit phase;
    acnt = 0; rcnt = 0; phase = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (!resp_en) begin
        dmem_gnt = man_gnt; dmem_rvalid = man_rvalid; dmem_rdata = 32'hDEAD_BEEF;
        acnt = 0; phase = 1'b0;
      end else if (dmem_req) begin
        phase = 1'b0;
        if (acnt == cur_g) begin
          dmem_gnt    = 1'b1;
          dmem_rvalid = ($urandom_range(0, 3) == 0);
          acnt = 0; rcnt = 0; phase = !dmem_we;
        end else begin
          acnt++;
        end
      end else begin
        acnt = 0;
        if (phase) begin
          if (rcnt == cur_r) begin
            dmem_rvalid = 1'b1; dmem_rdata = cur_rdata; phase = 1'b0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever MEM/WB would capture
  initial begin
    int stall_cnt, req_cnt;
    logic [31:0] c_addr, c_wdata;
    logic [3:0] c_be;
    logic c_we;
    exp_t e;
    stall_cnt = 0; req_cnt = 0; c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        stall_cnt = 0; req_cnt = 0;
      end else if (!ex_valid) begin
        chk("bubble_stall", 32'(mem_stall), 32'd0);
        chk("bubble_req", 32'(dmem_req), 32'd0);
      end else begin
        if (dmem_req) begin
          if (req_cnt == 0) begin
            c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
          end
          req_cnt++;
        end
        if (mem_stall) begin
          stall_cnt++;
        end else if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_empty: got completion expected none");
        end else begin
          e = sb.pop_front();
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          chk("mem_data", mem_data_o, e.mem_data);
          chk("reg_write", 32'(reg_write_o), 32'(e.reg_write));
          chk("misalign", 32'(misalign_o), 32'(e.misalign));
          chk("bus_err", 32'(bus_err_o), 32'(e.bus_err));
          chk("passthru_pc", pc_o, e.pc);
          chk("passthru_alu", alu_result_o, e.alu);
          chk("passthru_rd_wb", {25'd0, rd_addr_o, wb_sel_o}, {25'd0, e.rd, e.wb});
          if (e.req_cycles > 0) begin
            chk("req_addr", c_addr, e.addr);
            chk("req_be", 32'(c_be), 32'(e.be));
            chk("req_we", 32'(c_we), 32'(e.we));
            if (e.we) chk("req_wdata", c_wdata, e.wdata);
          end
          stall_cnt = 0; req_cnt = 0;
        end
      end
    end
  end

  task automatic issue(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                       logic [31:0] sd, int g, int r, logic [31:0] rdata);
    exp_t e;
    int size, need;
    bit memop, fault, tout, done;
    logic [31:0] sh, ld;
    e.pc = $urandom; e.alu = addr; e.rd = 5'($urandom); e.wb = 2'($urandom);
    e.reg_write = 1'($urandom);
    memop = rd | wr;
    size  = 1 << f3[1:0];
    fault = (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || ((addr % size) != 0);
    sh = rdata >> (8 * (addr % 4));
    case (size)
      1:       ld = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2:       ld = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld = rdata;
    endcase
    e.addr  = {addr[31:2], 2'b00};
    e.we    = wr;
    e.be    = wr ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
    e.wdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
    e.misalign = 1'b0; e.bus_err = 1'b0;
    if (!memop) begin
      e.stall = 0; e.req_cycles = 0; e.mem_data = last_mem_data;
    end else if (fault) begin
      e.stall = 1; e.req_cycles = 0; e.mem_data = 0;
      e.misalign = 1'b1; e.reg_write = 1'b0;
    end else begin
      need = wr ? g + 1 : g + r + 2;
      tout = need > TO;
      e.stall      = 1 + (tout ? TO : need);
      e.req_cycles = (g + 1 < TO) ? g + 1 : TO;
      e.bus_err    = tout;
      e.reg_write  = e.reg_write & !tout;
      e.mem_data   = (wr || tout) ? 32'd0 : ld;
    end
    last_mem_data = e.mem_data;
    sb.push_back(e);
    cur_g = g; cur_r = r; cur_rdata = rdata;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sd; ex_pc = e.pc;
    ex_rd_addr = e.rd; ex_wb_sel = e.wb; ex_reg_write = $urandom;
    if (!memop || !fault) ex_reg_write = e.reg_write | (memop & e.bus_err & ex_reg_write);
    if (memop && fault) ex_reg_write = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL stall_bound: got stall after 64 cycles expected release");
    end
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    ex_valid = 1'b0; ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
    ex_alu_result = $urandom; ex_funct3 = 3'($urandom);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic rand_txn();
    logic [2:0] legal [5];
    int k, g, r;
    bit rd, wr;
    logic [2:0] f3;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    k  = $urandom_range(0, 7);
    rd = (k >= 2 && k <= 4) || k == 7;
    wr = (k >= 5);
    f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
    g  = $urandom_range(0, 3);
    r  = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 2);
    issue(rd, wr, f3, $urandom, $urandom, g, r, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_pc = 0; ex_alu_result = 32'h100; ex_store_data = 0;
    ex_rd_addr = 0; ex_reg_write = 0; ex_wb_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(mem_stall), 32'd0);
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_mem_data", mem_data_o, 32'd0);
    chk("reset_misalign", 32'(misalign_o), 32'd0);
    chk("reset_bus_err", 32'(bus_err_o), 32'd0);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_FF12);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 2, 0, 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 0, 32'd0);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'd0, 0, 0, 32'h8001_0000);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'd0, 0, 0, 32'h8001_0000);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 100, 32'd0);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_5004, 32'd0, 0, 0, 32'd0);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'h1234_5678, 0, 0, 32'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_7000, 32'd0, 0, 0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) bubble();
      else rand_txn();
    end

    // Reset abandons transactions in ADDR and in DATA
    mon_en = 1'b0; resp_en = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_alu_result = 32'h0000_8000;
    @(posedge clk); #1;
    chk("rst_addr_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_addr_req", 32'(dmem_req), 32'd0);
    chk("rst_addr_stall", 32'(mem_stall), 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    man_gnt = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_data_stall_before", 32'(mem_stall), 32'd1);
    chk("rst_data_req_before", 32'(dmem_req), 32'd0);
    man_gnt = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_data_stall", 32'(mem_stall), 32'd0);
    ex_valid = 1'b0; man_rvalid = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    chk("late_rvalid_mem_data", mem_data_o, 32'd0);
    chk("late_rvalid_stall", 32'(mem_stall), 32'd0);
    chk("late_rvalid_req", 32'(dmem_req), 32'd0);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
